// File: rtl/data_mux_pkg.sv
// rtl/data_mux_pkg.sv - mode encoding, lock states and framing defaults shared by the mux link
package data_mux_pkg;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_DUAL   = 2'b10;
    localparam logic [1:0] MODE_TRIPLE = 2'b11;

    localparam int DEFAULT_CLK_DIV = 6;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    // Upper clip of a signed slot bound to the last phase of the frame.
    function automatic logic signed [5:0] clip_hi(input logic signed [5:0] a,
                                                  input logic signed [5:0] hi);
        return (a > hi) ? hi : a;
    endfunction

endpackage

// File: rtl/data_demultiplex_symbol_phase_counter.sv
// rtl/data_demultiplex_symbol_phase_counter.sv - free-running symbol phase with sync realignment
module symbol_phase_counter #(
    parameter int CLK_DIV = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sync,
    input  logic                       check_en,
    output logic [$clog2(CLK_DIV)-1:0] phase,
    output logic                       symbol_clk,
    output logic                       sync_err
);

    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0] count;

    // A sync always forces phase 0 in its own cycle, so the frame restarts immediately.
    assign phase = sync ? '0 : count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            symbol_clk <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            count      <= (phase == PW'(CLK_DIV - 1)) ? '0 : phase + PW'(1);
            symbol_clk <= (phase < PW'(CLK_DIV / 2));
            sync_err   <= sync && check_en && (count != '0);
        end
    end

endmodule

// File: rtl/data_demultiplex.sv
// rtl/data_demultiplex.sv - splits the time-multiplexed symbol stream back into DS1/DS2/DS3
module data_demultiplex
    import data_mux_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mux_data,
    input  logic       sync,
    input  logic [1:0] mode,
    input  logic [3:0] switch_clk_cycles,
    output logic [7:0] ds1_out,
    output logic [7:0] ds2_out,
    output logic [7:0] ds3_out,
    output logic       ds1_valid,
    output logic       ds2_valid,
    output logic       ds3_valid,
    output logic       symbol_clk,
    output logic       locked,
    output logic       sync_err
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic signed [5:0] LAST      = 6'(CLK_DIV - 1);
    localparam logic signed [5:0] HALF_LAST = 6'(CLK_DIV / 2 - 1);

    state_t            state;
    logic [1:0]        mode_f;
    logic [3:0]        s_f;
    logic [PW-1:0]     phase;
    logic              phase0;
    logic              active;
    logic [1:0]        cur_mode;
    logic [3:0]        cur_sw;
    logic signed [5:0] ph_s;
    logic signed [5:0] cur_s;
    logic signed [5:0] s_m1;
    logic signed [5:0] s_p1;
    logic              cap1;
    logic              cap2;
    logic              cap3;

    symbol_phase_counter #(
        .CLK_DIV (CLK_DIV)
    ) u_phase (
        .clk        (clk),
        .rst        (rst),
        .sync       (sync),
        .check_en   (state == LOCKED),
        .phase      (phase),
        .symbol_clk (symbol_clk),
        .sync_err   (sync_err)
    );

    // At phase 0 the frame config is being latched, so the live inputs already govern that cycle.
    assign phase0   = (phase == '0);
    assign cur_mode = phase0 ? mode : mode_f;
    assign cur_sw   = phase0 ? switch_clk_cycles : s_f;
    assign cur_s    = $signed({2'b00, cur_sw});
    assign s_m1     = cur_s - 6'sd1;
    assign s_p1     = cur_s + 6'sd1;
    assign ph_s     = $signed(6'(phase));
    assign active   = (state == LOCKED) || sync;

    // Each stream is captured at the last phase of its slot; empty slots never match.
    always_comb begin
        cap1 = 1'b0;
        cap2 = 1'b0;
        cap3 = 1'b0;
        case (cur_mode)
            MODE_IDLE: ;
            MODE_SINGLE: cap1 = (ph_s == LAST);
            MODE_DUAL: begin
                cap1 = (ph_s == HALF_LAST);
                cap2 = (ph_s == LAST);
            end
            MODE_TRIPLE: begin
                cap1 = (s_m1 >= 6'sd1) && (ph_s == clip_hi(s_m1 - 6'sd1, LAST));
                cap2 = (s_m1 <= LAST) && (ph_s == clip_hi(cur_s, LAST));
                cap3 = (s_p1 <= LAST) && (ph_s == LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= UNLOCKED;
            locked    <= 1'b0;
            mode_f    <= MODE_IDLE;
            s_f       <= 4'd0;
            ds1_out   <= 8'h00;
            ds2_out   <= 8'h00;
            ds3_out   <= 8'h00;
            ds1_valid <= 1'b0;
            ds2_valid <= 1'b0;
            ds3_valid <= 1'b0;
        end else begin
            ds1_valid <= 1'b0;
            ds2_valid <= 1'b0;
            ds3_valid <= 1'b0;

            case (state)
                UNLOCKED: if (sync) state <= LOCKED;
                LOCKED:   state <= LOCKED;
                default:  state <= UNLOCKED;
            endcase
            locked <= (state == LOCKED) || sync;

            if (phase0) begin
                mode_f <= mode;
                s_f    <= switch_clk_cycles;
            end

            if (active && cap1) begin
                ds1_out   <= mux_data;
                ds1_valid <= 1'b1;
            end
            if (active && cap2) begin
                ds2_out   <= mux_data;
                ds2_valid <= 1'b1;
            end
            if (active && cap3) begin
                ds3_out   <= mux_data;
                ds3_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_demultiplex.sv
// tb/tb_data_demultiplex.sv - directed table-driven bench for data_demultiplex (CLK_DIV=6)
module tb_data_demultiplex;
    import data_mux_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mux_data;
    logic       sync;
    logic [1:0] mode;
    logic [3:0] switch_clk_cycles;
    logic [7:0] ds1_out, ds2_out, ds3_out;
    logic       ds1_valid, ds2_valid, ds3_valid;
    logic       symbol_clk, locked, sync_err;

    data_demultiplex #(.CLK_DIV(6)) dut (
        .clk               (clk),
        .rst               (rst),
        .mux_data          (mux_data),
        .sync              (sync),
        .mode              (mode),
        .switch_clk_cycles (switch_clk_cycles),
        .ds1_out           (ds1_out),
        .ds2_out           (ds2_out),
        .ds3_out           (ds3_out),
        .ds1_valid         (ds1_valid),
        .ds2_valid         (ds2_valid),
        .ds3_valid         (ds3_valid),
        .symbol_clk        (symbol_clk),
        .locked            (locked),
        .sync_err          (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] s;
        int         cnt1;
        int         cnt2;
        int         cnt3;
        logic [7:0] v1;
        logic [7:0] v2;
        logic [7:0] v3;
    } vec_t;

    vec_t       vecs[10];
    int         tests = 0;
    int         fails = 0;
    int         tb_ph = 0;
    int         cyc = 0;
    int         cnt[3];
    logic [7:0] val[3];
    int         at[3];
    int         errs = 0;
    int         sc_bad = 0;
    int         lk_cycles = 0;
    int         sync_cyc;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear();
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0;
            val[k] = 8'h00;
            at[k]  = -1;
        end
    endtask

    // Drive one cycle (mux_data = 0x10 + bench phase), then sample 1 time unit after the edge.
    task automatic cycle(input logic s);
        int cur;
        cur = s ? 0 : tb_ph;
        sync = s;
        mux_data = 8'h10 + 8'(cur);
        @(posedge clk);
        #1;
        if (ds1_valid) begin cnt[0]++; val[0] = ds1_out; at[0] = cyc; end
        if (ds2_valid) begin cnt[1]++; val[1] = ds2_out; at[1] = cyc; end
        if (ds3_valid) begin cnt[2]++; val[2] = ds3_out; at[2] = cyc; end
        if (sync_err) errs++;
        if (locked) lk_cycles++;
        if (!rst && (symbol_clk !== (cur < 3))) sc_bad++;
        tb_ph = rst ? 0 : ((cur == 5) ? 0 : cur + 1);
        cyc++;
    endtask

    initial begin
        vecs[0] = '{2'b01, 4'd0, 1, 0, 0, 8'h15, 8'h00, 8'h00};
        vecs[1] = '{2'b10, 4'd0, 1, 1, 0, 8'h12, 8'h15, 8'h00};
        vecs[2] = '{2'b11, 4'd3, 1, 1, 1, 8'h11, 8'h13, 8'h15};
        vecs[3] = '{2'b11, 4'd0, 0, 1, 1, 8'h00, 8'h10, 8'h15};
        vecs[4] = '{2'b11, 4'd9, 1, 0, 0, 8'h15, 8'h00, 8'h00};
        vecs[5] = '{2'b11, 4'd1, 0, 1, 1, 8'h00, 8'h11, 8'h15};
        vecs[6] = '{2'b11, 4'd2, 1, 1, 1, 8'h10, 8'h12, 8'h15};
        vecs[7] = '{2'b11, 4'd5, 1, 1, 0, 8'h13, 8'h15, 8'h00};
        vecs[8] = '{2'b11, 4'd6, 1, 1, 0, 8'h14, 8'h15, 8'h00};
        vecs[9] = '{2'b00, 4'd3, 0, 0, 0, 8'h00, 8'h00, 8'h00};

        rst = 1'b1;
        sync = 1'b0;
        mode = 2'b01;
        switch_clk_cycles = 4'd0;
        mux_data = 8'h00;
        clear();
        repeat (3) cycle(1'b0);
        check("reset_outs", {ds1_out, ds2_out, ds3_out}, 0);
        check("reset_flags", {ds1_valid, ds2_valid, ds3_valid, symbol_clk, locked, sync_err}, 0);

        // Unlocked, no sync: nothing captured, no lock.
        rst = 1'b0;
        clear();
        errs = 0;
        lk_cycles = 0;
        sc_bad = 0;
        repeat (20) cycle(1'b0);
        check("idle_valids", cnt[0] + cnt[1] + cnt[2], 0);
        check("idle_locked", lk_cycles, 0);
        check("idle_outs", {ds1_out, ds2_out, ds3_out}, 0);

        // First sync lands off-phase while unlocked: lock without sync_err, that frame captures.
        clear();
        cycle(1'b1);
        check("lock_locked", locked, 1);
        repeat (5) cycle(1'b0);
        check("lock_no_err", errs, 0);
        check("lock_frame_cnt", cnt[0], 1);
        check("lock_frame_val", val[0], 8'h15);

        for (int i = 0; i < 10; i++) begin
            mode = vecs[i].mode;
            switch_clk_cycles = vecs[i].s;
            clear();
            repeat (6) cycle(1'b0);
            check($sformatf("v%0d_cnt1", i), cnt[0], vecs[i].cnt1);
            check($sformatf("v%0d_cnt2", i), cnt[1], vecs[i].cnt2);
            check($sformatf("v%0d_cnt3", i), cnt[2], vecs[i].cnt3);
            if (vecs[i].cnt1 != 0) check($sformatf("v%0d_val1", i), val[0], vecs[i].v1);
            if (vecs[i].cnt2 != 0) check($sformatf("v%0d_val2", i), val[1], vecs[i].v2);
            if (vecs[i].cnt3 != 0) check($sformatf("v%0d_val3", i), val[2], vecs[i].v3);
            if (vecs[i].mode == MODE_DUAL) check("dual_spacing", at[1] - at[0], 3);
        end
        check("table_locked", locked, 1);
        check("table_no_err", errs, 0);

        // Mode changed at phase 3: current frame keeps single mode.
        mode = 2'b01;
        repeat (6) cycle(1'b0);
        clear();
        repeat (3) cycle(1'b0);
        mode = 2'b10;
        repeat (3) cycle(1'b0);
        check("modechg_old_cnt1", cnt[0], 1);
        check("modechg_old_val1", val[0], 8'h15);
        check("modechg_old_cnt2", cnt[1], 0);
        clear();
        repeat (6) cycle(1'b0);
        check("modechg_new_val1", val[0], 8'h12);
        check("modechg_new_val2", val[1], 8'h15);

        // S changed at phase 3 in triple mode.
        mode = 2'b11;
        switch_clk_cycles = 4'd3;
        repeat (6) cycle(1'b0);
        clear();
        repeat (3) cycle(1'b0);
        switch_clk_cycles = 4'd0;
        repeat (3) cycle(1'b0);
        check("schg_old_val1", val[0], 8'h11);
        check("schg_old_val2", val[1], 8'h13);
        clear();
        repeat (6) cycle(1'b0);
        check("schg_new_cnt1", cnt[0], 0);
        check("schg_new_val2", val[1], 8'h10);

        // Off-phase sync at count 2 while locked.
        mode = 2'b01;
        repeat (6) cycle(1'b0);
        clear();
        errs = 0;
        cycle(1'b0);
        cycle(1'b0);
        sync_cyc = cyc;
        cycle(1'b1);
        repeat (5) cycle(1'b0);
        check("syncerr_pulses", errs, 1);
        check("syncerr_cnt1", cnt[0], 1);
        check("syncerr_val1", val[0], 8'h15);
        check("syncerr_realign", at[0] - sync_cyc, 5);
        check("syncerr_locked", locked, 1);
        check("syncerr_sclk_track", sc_bad, 0);

        // Sync on the old frame's capture phase drops that capture.
        clear();
        errs = 0;
        repeat (5) cycle(1'b0);
        cycle(1'b1);
        check("synccap_dropped", cnt[0], 0);
        check("synccap_err", errs, 1);
        repeat (5) cycle(1'b0);
        check("synccap_next", cnt[0], 1);

        // Reset at phase 4 with a coincident sync.
        mode = 2'b11;
        switch_clk_cycles = 4'd3;
        repeat (6) cycle(1'b0);
        repeat (4) cycle(1'b0);
        rst = 1'b1;
        cycle(1'b1);
        check("rst_outs", {ds1_out, ds2_out, ds3_out}, 0);
        check("rst_flags", {ds1_valid, ds2_valid, ds3_valid, symbol_clk, locked, sync_err}, 0);
        rst = 1'b0;
        clear();
        lk_cycles = 0;
        repeat (8) cycle(1'b0);
        check("rst_stays_unlocked", lk_cycles, 0);
        check("rst_no_captures", cnt[0] + cnt[1] + cnt[2], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
